// File: rtl/rand_interval_if.sv
// rand_interval_if: valid/ready bundle carrying a 4-bit blink interval.
interface rand_interval_if;
    logic [3:0] interval_data;
    logic       interval_valid;
    logic       interval_ready;

    modport master (
        output interval_data,
        output interval_valid,
        input  interval_ready
    );

    modport slave (
        input  interval_data,
        input  interval_valid,
        output interval_ready
    );
endinterface

// File: rtl/rand_interval_gen.sv
// rand_interval_gen: 16-bit LFSR filtered into a 2-entry interval FIFO.
// Optional LFSR_SEED_LOAD_EN adds seed_load/seed_in runtime reseeding.
module rand_interval_gen #(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter logic [3:0]  MIN_INTERVAL = 4'd1,
    parameter logic [3:0]  MAX_INTERVAL = 4'd15
) (
    input  logic        clk_edge,
    input  logic        rstbtn,
`ifdef LFSR_SEED_LOAD_EN
    input  logic        seed_load,
    input  logic [15:0] seed_in,
`endif
    rand_interval_if.master iv,
    output logic [7:0]  reject_cnt
);

    typedef enum logic {
        GEN,
        FULL
    } state_t;

    localparam logic [15:0] SEED_EFF =
        (SEED == 16'd0) ? 16'hACE1 : SEED;

    // Acceptance window folded into a lookup so the test is a single bit.
    function automatic logic [15:0] range_mask();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) begin
            m[i] = (i >= int'(MIN_INTERVAL)) &&
                   (i <= int'(MAX_INTERVAL));
        end
        return m;
    endfunction

    localparam logic [15:0] RANGE_MASK = range_mask();

    state_t      state;
    logic [15:0] lfsr;
    logic [3:0]  head;
    logic [3:0]  tail;
    logic [1:0]  cnt;
    logic        valid;

    logic [3:0]  cand;
    logic        feedback;
    logic        gen;
    logic        push;
    logic        pop;
    logic        reject;
    logic [3:0]  head_nxt;
    logic [3:0]  tail_nxt;
    logic [1:0]  cnt_nxt;

    assign cand     = lfsr[3:0];
    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign gen      = (state == GEN);
    assign push     = gen && RANGE_MASK[cand];
    assign reject   = gen && !RANGE_MASK[cand];
    assign pop      = valid && iv.interval_ready;

    assign iv.interval_data  = head;
    assign iv.interval_valid = valid;

    // Head is kept in its own register so the output never moves
    // until a pop.
    always_comb begin
        head_nxt = head;
        tail_nxt = tail;
        cnt_nxt  = cnt;
        unique case (cnt)
            2'd0: begin
                if (push) begin
                    head_nxt = cand;
                    cnt_nxt  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_nxt = cand;
                end else if (push) begin
                    tail_nxt = cand;
                    cnt_nxt  = 2'd2;
                end else if (pop) begin
                    cnt_nxt  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_nxt = tail;
                    if (push) begin
                        tail_nxt = cand;
                    end else begin
                        cnt_nxt = 2'd1;
                    end
                end
            end
            default: begin
                cnt_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_edge or posedge rstbtn) begin
        if (rstbtn) begin
            lfsr       <= SEED_EFF;
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            valid      <= 1'b0;
            state      <= GEN;
            reject_cnt <= '0;
        end
`ifdef LFSR_SEED_LOAD_EN
        else if (seed_load) begin
            lfsr       <= (seed_in == 16'd0) ? 16'hACE1 : seed_in;
            cnt        <= '0;
            valid      <= 1'b0;
            state      <= GEN;
            reject_cnt <= '0;
        end
`endif
        else begin
            if (gen) begin
                lfsr <= {lfsr[14:0], feedback};
            end
            head  <= head_nxt;
            tail  <= tail_nxt;
            cnt   <= cnt_nxt;
            valid <= (cnt_nxt != 2'd0);
            state <= (cnt_nxt == 2'd2) ? FULL : GEN;
            if (reject && (reject_cnt != 8'hFF)) begin
                reject_cnt <= reject_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_rand_interval_gen.sv
// tb_rand_interval_gen: directed and randomized checks against a queue model.
module tb_rand_interval_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a;
    logic       rst_b;
    logic [7:0] rc_a;
    logic [7:0] rc_b;

    rand_interval_if if_a ();
    rand_interval_if if_b ();

`ifdef LFSR_SEED_LOAD_EN
    logic        seed_load_a = 1'b0;
    logic [15:0] seed_in_a   = 16'd0;
    logic        seed_load_b = 1'b0;
    logic [15:0] seed_in_b   = 16'd0;
`endif

    rand_interval_gen dut_a (
        .clk_edge   (clk),
        .rstbtn     (rst_a),
`ifdef LFSR_SEED_LOAD_EN
        .seed_load  (seed_load_a),
        .seed_in    (seed_in_a),
`endif
        .iv         (if_a),
        .reject_cnt (rc_a)
    );

    rand_interval_gen #(
        .MIN_INTERVAL (4'd8),
        .MAX_INTERVAL (4'd8)
    ) dut_b (
        .clk_edge   (clk),
        .rstbtn     (rst_b),
`ifdef LFSR_SEED_LOAD_EN
        .seed_load  (seed_load_b),
        .seed_in    (seed_in_b),
`endif
        .iv         (if_b),
        .reject_cnt (rc_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: a plain queue of intervals plus the LFSR as an integer.
    logic [15:0] m_lfsr;
    int          m_q[$];
    int          m_rej;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int x;
        int fb;
        x  = int'(v);
        fb = ((x / 32768) + (x / 8192) + (x / 4096) + (x / 1024)) % 2;
        return 16'((x * 2 + fb) % 65536);
    endfunction

    task automatic model_reset();
        m_lfsr = 16'hACE1;
        m_q.delete();
        m_rej = 0;
    endtask

    task automatic model_edge(input int mn, input int mx, input bit rdy);
        bit do_pop;
        bit do_push;
        int c;
        do_pop  = rdy && (m_q.size() > 0);
        do_push = 1'b0;
        c       = 0;
        if (m_q.size() < 2) begin
            c      = int'(m_lfsr) % 16;
            m_lfsr = lfsr_step(m_lfsr);
            if (c >= mn && c <= mx) do_push = 1'b1;
            else if (m_rej < 255) m_rej++;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(c);
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.interval_ready = 1'b0;
        if_b.interval_ready = 1'b0;
        #12;
        n_checks++;
        if (if_a.interval_valid !== 1'b0)
            $display("FAIL reset_valid_a got %b want 0", if_a.interval_valid);
        else n_pass++;
        n_checks++;
        if (if_a.interval_data !== 4'd0)
            $display("FAIL reset_data_a got %0d want 0", if_a.interval_data);
        else n_pass++;
        n_checks++;
        if (rc_a !== 8'd0)
            $display("FAIL reset_rej_a got %0d want 0", rc_a);
        else n_pass++;
        n_checks++;
        if (if_b.interval_valid !== 1'b0 || rc_b !== 8'd0)
            $display("FAIL reset_b got v=%b r=%0d want 0/0",
                     if_b.interval_valid, rc_b);
        else n_pass++;
    endtask

    task automatic check_seq_137(input string tag);
        int exp_v[3] = '{1, 3, 7};
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (if_a.interval_valid !== 1'b1 ||
                if_a.interval_data !== 4'(exp_v[k]))
                $display("FAIL %s[%0d] got v=%b d=%0d want v=1 d=%0d",
                         tag, k, if_a.interval_valid,
                         if_a.interval_data, exp_v[k]);
            else n_pass++;
        end
        n_checks++;
        if (rc_a !== 8'd0)
            $display("FAIL %s_rej got %0d want 0", tag, rc_a);
        else n_pass++;
    endtask

    task automatic test_sequence();
        rst_a = 1'b1;
        if_a.interval_ready = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check_seq_137("seq");
    endtask

    task automatic test_full_hold();
        bit ok;
        rst_a = 1'b1;
        if_a.interval_ready = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n_checks++;
            if (if_a.interval_valid !== 1'b1 || if_a.interval_data !== 4'd1) begin
                $display("FAIL hold[%0d] got v=%b d=%0d want v=1 d=1",
                         k, if_a.interval_valid, if_a.interval_data);
                ok = 1'b0;
            end else n_pass++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (dut_a.lfsr !== 16'hB387)
            $display("FAIL frozen_lfsr got %h want b387", dut_a.lfsr);
        else n_pass++;
    endtask

    task automatic test_pulse();
        if_a.interval_ready = 1'b1;
        @(posedge clk);
        #1;
        if_a.interval_ready = 1'b0;
        n_checks++;
        if (if_a.interval_data !== 4'd3)
            $display("FAIL pulse_pop got %0d want 3", if_a.interval_data);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (if_a.interval_data !== 4'd3 || if_a.interval_valid !== 1'b1)
            $display("FAIL pulse_hold got v=%b d=%0d want v=1 d=3",
                     if_a.interval_valid, if_a.interval_data);
        else n_pass++;
        if_a.interval_ready = 1'b1;
        @(posedge clk);
        #1;
        if_a.interval_ready = 1'b0;
        n_checks++;
        if (if_a.interval_data !== 4'd7)
            $display("FAIL pulse_push7 got %0d want 7", if_a.interval_data);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        repeat (3) @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        n_checks++;
        if (if_a.interval_valid !== 1'b0 || if_a.interval_data !== 4'd0)
            $display("FAIL async_rst got v=%b d=%0d want v=0 d=0",
                     if_a.interval_valid, if_a.interval_data);
        else n_pass++;
        if_a.interval_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
        check_seq_137("restart");
    endtask

    task automatic run_random(input int which, input int mn, input int mx,
                              input int cycles, input int rdy_pct);
        bit rdy;
        logic       v;
        logic [3:0] d;
        logic [7:0] r;
        if (which == 0) rst_a = 1'b1;
        else rst_b = 1'b1;
        if_a.interval_ready = 1'b0;
        if_b.interval_ready = 1'b0;
        @(negedge clk);
        if (which == 0) rst_a = 1'b0;
        else rst_b = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            rdy = ($urandom_range(0, 99) < rdy_pct);
            if (which == 0) if_a.interval_ready = rdy;
            else if_b.interval_ready = rdy;
            @(posedge clk);
            model_edge(mn, mx, rdy);
            #1;
            v = (which == 0) ? if_a.interval_valid : if_b.interval_valid;
            d = (which == 0) ? if_a.interval_data : if_b.interval_data;
            r = (which == 0) ? rc_a : rc_b;
            n_checks++;
            if (v !== (m_q.size() != 0))
                $display("FAIL rnd%0d_valid@%0d got %b want %b",
                         which, i, v, (m_q.size() != 0));
            else n_pass++;
            if (m_q.size() != 0) begin
                n_checks++;
                if (d !== 4'(m_q[0]))
                    $display("FAIL rnd%0d_data@%0d got %0d want %0d",
                             which, i, d, m_q[0]);
                else n_pass++;
            end
            n_checks++;
            if (r !== 8'(m_rej))
                $display("FAIL rnd%0d_rej@%0d got %0d want %0d",
                         which, i, r, m_rej);
            else n_pass++;
        end
        if_a.interval_ready = 1'b0;
        if_b.interval_ready = 1'b0;
    endtask

    task automatic test_random_default();
        run_random(0, 1, 15, 400, 50);
    endtask

    task automatic test_narrow_saturate();
        run_random(1, 8, 8, 700, 75);
        n_checks++;
        if (rc_b !== 8'd255)
            $display("FAIL sat_rej got %0d want 255", rc_b);
        else n_pass++;
    endtask

`ifdef LFSR_SEED_LOAD_EN
    task automatic test_seed_load();
        if_a.interval_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        seed_in_a   = 16'd0;
        seed_load_a = 1'b1;
        @(posedge clk);
        #1;
        seed_load_a = 1'b0;
        n_checks++;
        if (dut_a.lfsr !== 16'hACE1)
            $display("FAIL seed_lfsr got %h want ace1", dut_a.lfsr);
        else n_pass++;
        n_checks++;
        if (if_a.interval_valid !== 1'b0 || rc_a !== 8'd0)
            $display("FAIL seed_flush got v=%b r=%0d want 0/0",
                     if_a.interval_valid, rc_a);
        else n_pass++;
        check_seq_137("seed");
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_full_hold();
        test_pulse();
        test_async_reset();
        test_random_default();
        test_narrow_saturate();
`ifdef LFSR_SEED_LOAD_EN
        test_seed_load();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
